// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and defaults for the UART TX round-robin arbiter
package uart_tx_arb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick starting at ptr
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest offset so the nearest requester wins last
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    j          = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N_REQ);
      if (req[j]) begin
        gnt_idx    = j;
        gnt_onehot = '0;
        gnt_onehot[j] = 1'b1;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART TX core among N_REQ clients
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   cfg_par_en,
  input  logic [N_REQ-1:0]   cfg_par_typ,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         P_DATA,
  output logic               PAR_EN,
  output logic               PAR_TYP,
  output logic               DATA_VALID,
  input  logic               Busy,
  output logic [IW-1:0]      grant_id,
  output logic               err_timeout
);
  state_t            state, nxt;
  logic [IW-1:0]     rr_ptr, gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic              any, take, last;
  logic [CW-1:0]     cnt;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_onehot(gnt),
    .gnt_idx   (gnt_idx),
    .any       (any)
  );

  // req_ready is gated by reset so no accept leaks out while state is forced to IDLE
  always_comb begin
    take        = (state == IDLE) && any && !Busy;
    last        = cnt == CW'(TIMEOUT - 1);
    req_ready   = (take && reset) ? gnt : '0;
    DATA_VALID  = state == ISSUE;
    err_timeout = (state == WAIT_BUSY) && !Busy && last;
    nxt         = state;
    case (state)
      IDLE:      nxt = take ? ISSUE : IDLE;
      ISSUE:     nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = Busy ? WAIT_DONE : (last ? IDLE : WAIT_BUSY);
      WAIT_DONE: nxt = Busy ? WAIT_DONE : IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      P_DATA   <= '0;
      PAR_EN   <= 1'b0;
      PAR_TYP  <= PAR_EVEN;
      grant_id <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == WAIT_BUSY) ? cnt + 1'b1 : '0;
      if (take) begin
        P_DATA   <= req_data[8*gnt_idx +: 8];
        PAR_EN   <= cfg_par_en[gnt_idx];
        PAR_TYP  <= cfg_par_typ[gnt_idx];
        grant_id <= gnt_idx;
        rr_ptr   <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for the UART TX arbiter
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  cfg_par_en, cfg_par_typ;
  logic [3:0]  req_ready;
  logic [7:0]  P_DATA;
  logic        PAR_EN, PAR_TYP, DATA_VALID, Busy, err_timeout;
  logic [1:0]  grant_id;
  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .req_ready(req_ready),
    .P_DATA(P_DATA), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .DATA_VALID(DATA_VALID),
    .Busy(Busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full frame from IDLE: accept, issue, Busy for a few cycles, back to IDLE
  task automatic frame(input logic [3:0] v, input int g, input logic [7:0] d,
                       input logic en, input logic typ, input logic [3:0] keep);
    req_valid = v;
    #1;
    chk("ready", 32'(req_ready), 32'(1 << g));
    chk("dv_idle", 32'(DATA_VALID), 0);
    @(negedge clk);
    chk("dv_issue", 32'(DATA_VALID), 1);
    chk("ready_issue", 32'(req_ready), 0);
    chk("pdata", 32'(P_DATA), 32'(d));
    chk("par_en", 32'(PAR_EN), 32'(en));
    chk("par_typ", 32'(PAR_TYP), 32'(typ));
    chk("grant_id", 32'(grant_id), 32'(g));
    req_valid   = req_valid & keep;
    Busy        = 1'b1;
    cfg_par_en  = ~cfg_par_en;
    cfg_par_typ = ~cfg_par_typ;
    repeat (3) begin
      @(negedge clk);
      chk("dv_busy", 32'(DATA_VALID), 0);
      chk("ready_busy", 32'(req_ready), 0);
      chk("pdata_hold", 32'(P_DATA), 32'(d));
      chk("par_en_hold", 32'(PAR_EN), 32'(en));
      chk("par_typ_hold", 32'(PAR_TYP), 32'(typ));
    end
    Busy        = 1'b0;
    cfg_par_en  = ~cfg_par_en;
    cfg_par_typ = ~cfg_par_typ;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; req_valid = 4'b0101; req_data = 32'h13121110;
    cfg_par_en = 4'b0; cfg_par_typ = 4'b0; Busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_pdata", 32'(P_DATA), 0);
    chk("rst_dv", 32'(DATA_VALID), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_par", 32'({PAR_EN, PAR_TYP}), 0);
    req_valid = 4'b0;
    reset = 1'b1;
    @(negedge clk);
    // All four held: 0,1,2,3,0
    frame(4'b1111, 0, 8'h10, 1'b0, 1'b0, 4'b1111);
    frame(4'b1111, 1, 8'h11, 1'b0, 1'b0, 4'b1111);
    frame(4'b1111, 2, 8'h12, 1'b0, 1'b0, 4'b1111);
    frame(4'b1111, 3, 8'h13, 1'b0, 1'b0, 4'b1111);
    frame(4'b1111, 0, 8'h10, 1'b0, 1'b0, 4'b0000);
    // Single client 0 with odd parity
    req_data[7:0] = 8'hA5; cfg_par_en = 4'b0001; cfg_par_typ = 4'b0001;
    frame(4'b0001, 0, 8'hA5, 1'b1, 1'b1, 4'b0000);
    frame(4'b0010, 1, 8'h11, 1'b0, 1'b0, 4'b0000);
    // rr_ptr=2 with clients 1,3: 3 then 1
    frame(4'b1010, 3, 8'h13, 1'b0, 1'b0, 4'b0010);
    frame(4'b0010, 1, 8'h11, 1'b0, 1'b0, 4'b0000);
    // Busy never rises: err_timeout exactly 16 cycles after DATA_VALID
    req_valid = 4'b0001;
    #1 chk("to_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("to_dv", 32'(DATA_VALID), 1);
    req_valid = 4'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("to_err", 32'(err_timeout), (k == 16) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("to_err_off", 32'(err_timeout), 0);
    frame(4'b0100, 2, 8'h12, 1'b0, 1'b0, 4'b0000);
    // Client 2 withdraws while client 0 is served (rr_ptr=3)
    frame(4'b0101, 0, 8'hA5, 1'b1, 1'b1, 4'b0000);
    repeat (3) begin
      chk("drop_ready", 32'(req_ready), 0);
      chk("drop_dv", 32'(DATA_VALID), 0);
      @(negedge clk);
    end
    // Reset during WAIT_DONE with rr_ptr=2 pending
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0; Busy = 1'b1;
    repeat (2) @(negedge clk);
    req_valid = 4'b0101;
    chk("wd_ready", 32'(req_ready), 0);
    chk("wd_pdata", 32'(P_DATA), 32'h11);
    reset = 1'b0; Busy = 1'b0;
    #1;
    chk("arst_pdata", 32'(P_DATA), 0);
    chk("arst_gid", 32'(grant_id), 0);
    chk("arst_ready", 32'(req_ready), 0);
    chk("arst_dv_err", 32'({DATA_VALID, err_timeout, PAR_EN, PAR_TYP}), 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("post_rst_dv", 32'(DATA_VALID), 1);
    chk("post_rst_gid", 32'(grant_id), 0);
    chk("post_rst_pdata", 32'(P_DATA), 32'hA5);
    req_valid = 4'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter among N_REQ byte-producing clients. Each client presents a byte with a valid/ready handshake. The block picks one client, loads the byte and that client's parity configuration onto the transmitter's P_DATA/PAR_EN/PAR_TYP, and pulses DATA_VALID. It then tracks the transmitter's Busy until the frame completes. It sits directly between the client logic and the UART TX core and is the only driver of the TX core's input pins.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 16: max cycles to wait for Busy to rise after DATA_VALID.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  client i has a byte pending; held until its req_ready pulse.
- req_data  in  N_REQ×8  packed byte per client; client i at bits [8i+7:8i].
- cfg_par_en  in  N_REQ  per-client parity enable, quasi-static.
- cfg_par_typ  in  N_REQ  per-client parity type (0 even, 1 odd), quasi-static.
- req_ready  out  N_REQ  one-cycle accept pulse, at most one bit set.
- P_DATA  out  8  byte to transmitter, registered.
- PAR_EN  out  1  parity enable to transmitter, registered.
- PAR_TYP  out  1  parity type to transmitter, registered.
- DATA_VALID  out  1  one-cycle start pulse to transmitter.
- Busy  in  1  transmitter busy flag.
- grant_id  out  $clog2(N_REQ)  index of the client owning the current or last frame.
- err_timeout  out  1  one-cycle pulse when Busy failed to rise.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Waits until some req_valid bit is set and Busy=0.
  - Then the rotating-priority pick g starts at rr_ptr.
  - req_ready[g]=1 in that same cycle, combinational from state and grant.
  - P_DATA, PAR_EN, PAR_TYP and grant_id capture client g's byte and config at the clock edge.
  - rr_ptr becomes (g+1) mod N_REQ.
  - Next state is ISSUE.
- ISSUE: DATA_VALID=1 for exactly this cycle. Next state is WAIT_BUSY, and the timeout counter clears to 0.
- WAIT_BUSY:
  - Busy=1 moves to WAIT_DONE.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT-1 with Busy still 0, err_timeout pulses for 1 cycle and the state returns to IDLE. The byte is dropped and not retried.
- WAIT_DONE: Busy=0 moves to IDLE.
- P_DATA, PAR_EN and PAR_TYP hold their values from capture until the next capture. They are stable for the whole frame.
- Round-robin rule: priority order is rr_ptr, rr_ptr+1, …, wrapping at N_REQ. A client that has just been served has the lowest priority next time.
- A client dropping req_valid before its ready pulse is legal; it is simply not granted.
- Config changes mid-frame have no effect until the next capture.
- Reset asserted at any time forces all state and outputs to their reset values immediately:
  - state=IDLE, rr_ptr=0, counter 0.
  - P_DATA=0, PAR_EN=0, PAR_TYP=0, DATA_VALID=0.
  - req_ready=0, grant_id=0, err_timeout=0.
  - An in-flight frame is abandoned and no ready pulse is owed.

## Timing
- Accept latency: req_ready[g] in cycle t, then DATA_VALID in t+1.
- Minimum frame spacing: from Busy falling (sampled in WAIT_DONE at cycle u), IDLE is reached at u+1. With a request pending, req_ready fires at u+1 and DATA_VALID at u+2.
- DATA_VALID is never asserted while the registered state is anything but ISSUE. ISSUE is only entered from IDLE with Busy=0 sampled.
- Busy high already in the ISSUE cycle counts from the WAIT_BUSY cycle onward. Normal TX cores raise Busy one cycle after DATA_VALID.
- Timeout window: DATA_VALID at t, then err_timeout at t+TIMEOUT if Busy stays 0.

## Structure
- Shared package uart_tx_arb_pkg holds:
  - state enum (IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3);
  - default N_REQ and TIMEOUT;
  - PAR_EVEN/PAR_ODD constants.
- Sub-module rr_arbiter: purely combinational.
  - Inputs: req[N_REQ] and ptr.
  - Outputs: gnt_onehot, gnt_idx, any.
  - Unit-tested standalone.
- Top holds the FSM, rr_ptr, timeout counter and output registers.

## Test plan
- Single client 0, req_data=0xA5, cfg_par_en=1, cfg_par_typ=1:
  - req_ready[0] at t, DATA_VALID at t+1;
  - P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 held until Busy falls;
  - grant_id=0.
- All four clients valid with bytes 0x10..0x13, held continuously:
  - grants in order 0,1,2,3,0;
  - exactly one req_ready per frame;
  - no DATA_VALID while Busy=1.
- Clients 1 and 3 valid with rr_ptr=2: client 3 is granted first, then 1.
- Transmitter model that never raises Busy:
  - err_timeout pulses exactly TIMEOUT cycles after DATA_VALID;
  - FSM is back in IDLE and serves the next request normally.
- Reset pulled low during WAIT_DONE: all outputs 0 within the same cycle; after release, the first grant goes to the lowest-index valid client (rr_ptr=0).
- Client 2 raises req_valid then drops it before being granted while client 0 is served: no req_ready[2]; no phantom frame.
